// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Grants one producer per cycle, stages the winning write and flags read
// addresses that hit the staged write so the datapath can forward it.
module regfile_wb_arbiter #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         write_reg_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic [N_REQ-1:0]          wb_src,
    input  logic [ADDR_W-1:0]         read_reg1_addr,
    input  logic [ADDR_W-1:0]         read_reg2_addr,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [CNT_W-1:0]          conflict_cnt
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              multi_valid;
    logic              seen_valid;

    // Modular add on the requester index; explicit compare so non-power-of-two
    // N_REQ wraps correctly instead of relying on bit truncation.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + SUM_W'(off);
        if (sum >= SUM_W'(N_REQ)) begin
            sum = sum - SUM_W'(N_REQ);
        end
        return sum[PTR_W-1:0];
    endfunction

    // Scan from rr_ptr upward (wrapping) and pick the first valid requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = wrap_add(rr_ptr, k);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // One-hot ready plus address/data mux for the granted requester.
    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_any && (grant_idx == PTR_W'(i))) begin
                req_ready[i] = 1'b1;
                sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
                sel_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Detect two or more simultaneous requests for the conflict counter.
    always_comb begin
        multi_valid = 1'b0;
        seen_valid  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                if (seen_valid) begin
                    multi_valid = 1'b1;
                end
                seen_valid = 1'b1;
            end
        end
    end

    // Round-robin pointer: moves just past the winner, holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= wrap_add(grant_idx, 1);
        end
    end

    // Output stage: stage the granted write; writes to $zero are consumed
    // but never enabled. Address/data hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite       <= 1'b0;
            write_reg_addr <= '0;
            write_data     <= '0;
            wb_src         <= '0;
        end else if (grant_any) begin
            RegWrite       <= (sel_addr != '0);
            write_reg_addr <= sel_addr;
            write_data     <= sel_data;
            wb_src         <= req_ready;
        end else begin
            RegWrite       <= 1'b0;
            wb_src         <= '0;
        end
    end

    // Saturating count of cycles with competing requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (multi_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    // Forwarding hits against the write committing at the next edge; $zero never hits.
    assign fwd_hit1 = RegWrite && (write_reg_addr == read_reg1_addr) && (read_reg1_addr != '0);
    assign fwd_hit2 = RegWrite && (write_reg_addr == read_reg2_addr) && (read_reg2_addr != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset behaviour, a vector table of
// grants/staging/forwarding, counter saturation and mid-stream reset.
module tb_regfile_wb_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            RegWrite;
    logic [AW-1:0]   write_reg_addr;
    logic [DW-1:0]   write_data;
    logic [N-1:0]    wb_src;
    logic [AW-1:0]   read_reg1_addr;
    logic [AW-1:0]   read_reg2_addr;
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [CW-1:0]   conflict_cnt;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .RegWrite       (RegWrite),
        .write_reg_addr (write_reg_addr),
        .write_data     (write_data),
        .wb_src         (wb_src),
        .read_reg1_addr (read_reg1_addr),
        .read_reg2_addr (read_reg2_addr),
        .fwd_hit1       (fwd_hit1),
        .fwd_hit2       (fwd_hit2),
        .conflict_cnt   (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [1:0]  ready;
        logic        rw;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  src;
        logic        h1;
        logic        h2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [4:0] r1, input logic [4:0] r2);
        req_valid      = v;
        req_addr       = {a1, a0};
        req_data       = {d1, d0};
        read_reg1_addr = r1;
        read_reg2_addr = r2;
    endtask

    initial begin
        // Table runs from rr_ptr=0 with idle outputs.
        //           valid  a0     a1     d0            d1            r1     r2     ready  rw    waddr  wdata         src    h1    h2
        vecs[0] = '{2'b10, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 5'd5,  5'd0,  2'b10, 1'b1, 5'd5,  32'hDEADBEEF, 2'b10, 1'b1, 1'b0};
        vecs[1] = '{2'b01, 5'd0,  5'd0,  32'h1234,     32'h0,        5'd0,  5'd0,  2'b01, 1'b0, 5'd0,  32'h1234,     2'b01, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 5'd7,  5'd0,  32'h77,       32'h0,        5'd7,  5'd8,  2'b01, 1'b1, 5'd7,  32'h77,       2'b01, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  5'd8,  2'b00, 1'b0, 5'd7,  32'h77,       2'b00, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       5'd4,  5'd3,  2'b10, 1'b1, 5'd4,  32'h44,       2'b10, 1'b1, 1'b0};
        vecs[5] = '{2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       5'd4,  5'd3,  2'b01, 1'b1, 5'd3,  32'h33,       2'b01, 1'b0, 1'b1};
        vecs[6] = '{2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       5'd4,  5'd3,  2'b10, 1'b1, 5'd4,  32'h44,       2'b10, 1'b1, 1'b0};
        vecs[7] = '{2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       5'd4,  5'd3,  2'b01, 1'b1, 5'd3,  32'h33,       2'b01, 1'b0, 1'b1};

        // Reset with every requester valid.
        rst = 1'b1;
        drive(2'b11, 5'd2, 5'd9, 32'h22, 32'h99, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_regwrite", 32'(RegWrite), 32'h0);
        chk("rst_waddr", 32'(write_reg_addr), 32'h0);
        chk("rst_wdata", write_data, 32'h0);
        chk("rst_src", 32'(wb_src), 32'h0);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);

        // Release: requester 0 wins the first cycle.
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("rel_regwrite", 32'(RegWrite), 32'h1);
        chk("rel_waddr", 32'(write_reg_addr), 32'h2);
        chk("rel_wdata", write_data, 32'h22);
        chk("rel_src", 32'(wb_src), 32'h1);
        chk("rel_cnt", 32'(conflict_cnt), 32'h1);

        // Reset mid-stream drops the staged write at once and rewinds the pointer.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_regwrite", 32'(RegWrite), 32'h0);
        chk("mid_rst_src", 32'(wb_src), 32'h0);
        chk("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

        // Vector table: ready before the edge, staged write and hits after it.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regwrite", i), 32'(RegWrite), 32'(vecs[i].rw));
            chk($sformatf("v%0d_waddr", i), 32'(write_reg_addr), 32'(vecs[i].waddr));
            chk($sformatf("v%0d_wdata", i), write_data, vecs[i].wdata);
            chk($sformatf("v%0d_src", i), 32'(wb_src), 32'(vecs[i].src));
            chk($sformatf("v%0d_hit1", i), 32'(fwd_hit1), 32'(vecs[i].h1));
            chk($sformatf("v%0d_hit2", i), 32'(fwd_hit2), 32'(vecs[i].h2));
        end
        chk("rr_cnt", 32'(conflict_cnt), 32'h4);

        // Twenty more conflict cycles saturate the 4-bit counter at 15.
        @(negedge clk);
        drive(2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 5'd0, 5'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", 32'(conflict_cnt), 32'hF);
        chk("sat_regwrite", 32'(RegWrite), 32'h1);

        // Reset during an active grant clears every output in the same cycle.
        rst = 1'b1;
        #1;
        chk("end_rst_regwrite", 32'(RegWrite), 32'h0);
        chk("end_rst_waddr", 32'(write_reg_addr), 32'h0);
        chk("end_rst_wdata", write_data, 32'h0);
        chk("end_rst_src", 32'(wb_src), 32'h0);
        chk("end_rst_cnt", 32'(conflict_cnt), 32'h0);
        chk("end_rst_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("end_rel_ready", 32'(req_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
